// File: rtl/csr_pkg.sv
// Shared CSR constants and response-channel types, used by both the read
// responder and the write-side CSR instances.
package csr_pkg;

  localparam int CSR_WIDTH    = 32;
  localparam int CSR_NUM_REGS = 8;
  localparam int CSR_ADDR_W   = 4;
  localparam int CSR_STS_ADDR = 8;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_HOLD = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [CSR_WIDTH-1:0] data;
    logic                 err;
  } csr_rsp_t;

endpackage

// File: rtl/csr_sticky.sv
// Sticky status register: event bits accumulate every cycle; a clear loads
// only the current events so a pulse coincident with the clear is never lost.
module csr_sticky #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_set,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_q <= '0;
    else if (i_clr) r_q <= i_set;
    else            r_q <= r_q | i_set;
  end

  assign o_q = r_q;

endmodule

// File: rtl/csr_rd_resp.sv
// CSR read responder: one-deep registered response slot with backpressure,
// address decode over the flat CSR bus, and a clear-on-read sticky status.
module csr_rd_resp
  import csr_pkg::*;
#(
  parameter int WIDTH    = CSR_WIDTH,
  parameter int NUM_REGS = CSR_NUM_REGS,
  parameter int ADDR_W   = CSR_ADDR_W,
  parameter int STS_ADDR = CSR_STS_ADDR
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [NUM_REGS*WIDTH-1:0] csr_flat,
  input  logic [WIDTH-1:0]          sts_set,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic [WIDTH-1:0]          sts_q
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SLOTS = 1 << IDX_W;

  rsp_state_e       r_state;
  logic             r_live;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic [WIDTH-1:0] w_regs [SLOTS];
  logic             w_accept;
  logic             w_is_csr;
  logic             w_is_sts;
  logic [WIDTH-1:0] w_sts_q;
  csr_rsp_t         w_rd;

  // Pad the register view to a power of two so the index mux never goes out of range.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < NUM_REGS) begin : g_reg
      assign w_regs[g] = csr_flat[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_regs[g] = '0;
    end
  end

  assign w_is_csr = (req_addr < ADDR_W'(NUM_REGS));
  assign w_is_sts = (req_addr == ADDR_W'(STS_ADDR));

  always_comb begin
    w_rd.data = '0;
    w_rd.err  = 1'b1;
    if (w_is_csr) begin
      w_rd.data = w_regs[req_addr[IDX_W-1:0]];
      w_rd.err  = 1'b0;
    end else if (w_is_sts) begin
      w_rd.data = w_sts_q;
      w_rd.err  = 1'b0;
    end
  end

  // r_live keeps req_ready low through reset and rises on the first edge after it.
  assign req_ready = r_live & ((r_state == RSP_IDLE) | rsp_ready);
  assign w_accept  = req_valid & req_ready;

  csr_sticky #(.WIDTH(WIDTH)) u_sts (
    .clk   (clk),
    .rstn  (rstn),
    .i_set (sts_set),
    .i_clr (w_accept & w_is_sts),
    .o_q   (w_sts_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= RSP_IDLE;
      r_live      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        RSP_IDLE: begin
          if (w_accept) begin
            r_state     <= RSP_HOLD;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd.data;
            r_rsp_err   <= w_rd.err;
          end
        end
        RSP_HOLD: begin
          // An accept in HOLD implies rsp_ready, so the old response drains this edge.
          if (w_accept) begin
            r_rsp_data <= w_rd.data;
            r_rsp_err  <= w_rd.err;
          end else if (rsp_ready) begin
            r_state     <= RSP_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= RSP_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign sts_q     = w_sts_q;

endmodule

// File: tb/tb_csr_rd_resp.sv
// Scoreboard bench for csr_rd_resp: requests push expected responses, a
// negedge monitor pops them on each response handshake.
module tb_csr_rd_resp;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_addr = '0;
  logic [255:0] csr_flat;
  logic [31:0]  sts_set = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic [31:0]  sts_q;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  csr_rd_resp dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .csr_flat  (csr_flat),
    .sts_set   (sts_set),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .sts_q     (sts_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one read; entered and left at posedge+1.
  task automatic rd(input logic [3:0] a, input logic [31:0] d, input logic e);
    int t = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept_timeout: addr %h never accepted", a);
    end else begin
      sb.push_back('{d: d, e: e});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: pop on handshake, and check data held steady while stalled.
  initial begin
    logic [31:0] pd;
    logic        ph;
    exp_t        x;
    ph = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ph = 1'b0;
      end else begin
        if (ph && rsp_valid) chk("hold_stable", rsp_data, pd);
        ph = rsp_valid && !rsp_ready;
        pd = rsp_data;
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: data %h err %b", rsp_data, rsp_err);
          end else begin
            x = sb.pop_front();
            chk("rsp_data", rsp_data, x.d);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, x.e});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++)
      csr_flat[i*32 +: 32] = (i == 3) ? 32'hDEAD_BEEF : 32'hA5A5_0000 + i;

    // reset state
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_sts_q", sts_q, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);

    // single read, one-cycle latency, then valid drops
    rd(4'd3, 32'hDEAD_BEEF, 1'b0);
    chk("single_valid", {31'b0, rsp_valid}, 32'h1);
    chk("single_data", rsp_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chk("single_valid_drop", {31'b0, rsp_valid}, 32'h0);

    // boundary registers back-to-back
    rd(4'd7, 32'hA5A5_0007, 1'b0);
    rd(4'd0, 32'hA5A5_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: three stalled cycles after the first accept
    rsp_ready = 1'b0;
    fork
      begin
        rd(4'd0, 32'hA5A5_0000, 1'b0);
        rd(4'd1, 32'hA5A5_0001, 1'b0);
        rd(4'd2, 32'hA5A5_0002, 1'b0);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 3; i++) begin
          chk("stall_req_ready", {31'b0, req_ready}, 32'h0);
          chk("stall_data", rsp_data, 32'hA5A5_0000);
          if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // sticky clear-on-read
    sts_set = 32'h5;
    @(posedge clk);
    #1 sts_set = '0;
    chk("sts_set", sts_q, 32'h5);
    rd(4'd8, 32'h5, 1'b0);
    chk("sts_cleared", sts_q, 32'h0);
    rd(4'd8, 32'h0, 1'b0);

    // event in the same cycle as the clearing read survives
    sts_set = 32'h1;
    @(posedge clk);
    #1 sts_set = 32'h8;
    rd(4'd8, 32'h1, 1'b0);
    sts_set = '0;
    chk("sts_race", sts_q, 32'h8);
    rd(4'd8, 32'h8, 1'b0);
    chk("sts_race_clear", sts_q, 32'h0);

    // undecoded addresses, then a good read
    rd(4'hF, 32'h0, 1'b1);
    rd(4'h9, 32'h0, 1'b1);
    rd(4'd2, 32'hA5A5_0002, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // reset while a response is stalled
    sts_set = 32'h30;
    @(posedge clk);
    #1 sts_set = '0;
    rsp_ready = 1'b0;
    rd(4'hE, 32'h0, 1'b1);
    chk("pre_rst_err", {31'b0, rsp_err}, 32'h1);
    chk("pre_rst_sts", sts_q, 32'h30);
    #3 rstn = 1'b0;
    #1;
    sb.delete();
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midrst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("midrst_sts_q", sts_q, 32'h0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rerst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rerst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    rd(4'd3, 32'hDEAD_BEEF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
